// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access sizes, FSM states and
// alignment helpers.
`timescale 1ns/1ps
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    WRITE,
    RESP
  } state_t;

  // The reserved size code behaves exactly like a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_B:    is_misaligned = 1'b0;
      SZ_H:    is_misaligned = addr_lo[0];
      SZ_W:    is_misaligned = (addr_lo != 2'b00);
      default: is_misaligned = (addr_lo != 2'b00);
    endcase
  endfunction

  function automatic logic [31:0] force_align(input logic [1:0] size, input logic [31:0] addr);
    case (size)
      SZ_B:    force_align = addr;
      SZ_H:    force_align = {addr[31:1], 1'b0};
      default: force_align = {addr[31:2], 2'b00};
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane datapath: extracts and sign/zero-extends load lanes, and merges
// store data into a read word (little-endian, lane 0 = bits [7:0]).
`timescale 1ns/1ps
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rd_word[{addr_lo, 3'b000} +: 8];
    half_sel = rd_word[{addr_lo[1], 4'b0000} +: 16];

    case (size)
      SZ_B:    load_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      SZ_H:    load_data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      default: load_data = rd_word;
    endcase

    merged = rd_word;
    case (size)
      SZ_B:    merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      SZ_H:    merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store unit converting core byte/half/word accesses into a word memory
// interface. Define LSU_MISALIGN_TRAP_EN to report misaligned accesses as errors.
`timescale 1ns/1ps
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int WORD_ADDR = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_WE,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  input  logic [31:0] mem_RD
);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        err_q, err_d;

  logic        trap;
  logic [31:0] acc_addr;
  logic [31:0] load_data;
  logic [31:0] merged;

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap     = is_misaligned(req_size, req_addr[1:0]);
  assign acc_addr = req_addr;
`else
  assign trap     = 1'b0;
  assign acc_addr = force_align(req_size, req_addr);
`endif

  lsu_align u_align (
    .rd_word     (mem_RD),
    .wdata       (wdata_q),
    .size        (size_q),
    .addr_lo     (addr_q[1:0]),
    .is_unsigned (uns_q),
    .load_data   (load_data),
    .merged      (merged)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = acc_addr;
          size_d  = req_size;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
          merge_d = req_wdata;
          rdata_d = 32'h0;
          err_d   = trap;
          if (trap)
            state_d = RESP;
          else if (!req_we)
            state_d = LOAD;
          else if (req_size == SZ_B || req_size == SZ_H)
            state_d = RMW_RD;
          else
            state_d = WRITE;
        end
      end
      LOAD: begin
        rdata_d = load_data;
        state_d = RESP;
      end
      RMW_RD: begin
        merge_d = merged;
        state_d = WRITE;
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      merge_q <= 32'h0;
      rdata_q <= 32'h0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
    end
  end

  logic mem_active;
  assign mem_active = (state_q == LOAD) || (state_q == RMW_RD) || (state_q == WRITE);

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign mem_WE    = (state_q == WRITE);
  assign mem_WD    = (state_q == WRITE) ? merge_q : 32'h0;
  assign mem_A     = !mem_active      ? 32'h0 :
                     (WORD_ADDR != 0) ? {2'b00, addr_q[31:2]} :
                                        {addr_q[31:2], 2'b00};

endmodule
